// File: rtl/number_match_engine.sv
// rtl/number_match_engine.sv - guess-the-number round FSM driven by a 16-bit LFSR; ATTEMPT_LIMIT_EN adds a miss limit with game_over
module number_match_engine #(
    parameter int WIDTH        = 4,
    parameter int GEN_CYCLES   = 25_000_000,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int MAX_ATTEMPTS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             guess_valid,
    input  logic [WIDTH-1:0] guess,
    output logic             match,
    output logic             not_match,
    output logic [WIDTH-1:0] target,
    output logic             busy,
    output logic             game_over
);

    localparam int GW = (GEN_CYCLES > 1) ? $clog2(GEN_CYCLES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (WIDTH < 1 || WIDTH > 16 || GEN_CYCLES < 1 || HOLD_CYCLES < 1 || MAX_ATTEMPTS < 1) begin : g_bad_params
        $error("number_match_engine: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        WAIT_GUESS,
        CHECK,
        SHOW_MATCH,
        SHOW_MISS
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [15:0]       lfsr;
    logic              lfsr_fb;
    logic [GW-1:0]     gen_cnt;
    logic [HW-1:0]     hold_cnt;
    logic [WIDTH-1:0]  guess_q;
    logic              gen_done;
    logic              hold_done;
    logic              showing;
    logic              limit_hit;

    // Taps 16,14,13,11 in right-shifting Fibonacci form
    assign lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign gen_done  = (gen_cnt == GW'(GEN_CYCLES - 1));
    assign hold_done = (hold_cnt == HW'(HOLD_CYCLES - 1));
    assign showing   = (state == SHOW_MATCH) || (state == SHOW_MISS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        match      = 1'b0;
        not_match  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = GEN;
            end
            GEN: begin
                if (gen_done) state_next = WAIT_GUESS;
            end
            WAIT_GUESS: begin
                if (guess_valid) state_next = CHECK;
            end
            CHECK: begin
                state_next = (guess_q == target) ? SHOW_MATCH : SHOW_MISS;
            end
            SHOW_MATCH: begin
                match = 1'b1;
                if (hold_done) state_next = IDLE;
            end
            SHOW_MISS: begin
                not_match = 1'b1;
                if (hold_done) state_next = limit_hit ? IDLE : WAIT_GUESS;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Counters clear whenever their state is not active, so each state starts at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr     <= 16'hACE1;
            gen_cnt  <= '0;
            hold_cnt <= '0;
            target   <= '0;
            guess_q  <= '0;
        end else begin
            lfsr     <= {lfsr_fb, lfsr[15:1]};
            gen_cnt  <= (state == GEN && !gen_done) ? gen_cnt + 1'b1 : '0;
            hold_cnt <= (showing && !hold_done) ? hold_cnt + 1'b1 : '0;
            if (state == GEN && gen_done) target <= lfsr[WIDTH-1:0];
            if (state == WAIT_GUESS && guess_valid) guess_q <= guess;
        end
    end

`ifdef ATTEMPT_LIMIT_EN
    localparam int MW = $clog2(MAX_ATTEMPTS + 1);

    logic [MW-1:0] miss_cnt;

    assign limit_hit = (miss_cnt == MW'(MAX_ATTEMPTS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt  <= '0;
            game_over <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                miss_cnt <= '0;
            end else if (state == CHECK && guess_q != target) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            game_over <= (state == SHOW_MISS) && hold_done && limit_hit;
        end
    end
`else
    assign limit_hit = 1'b0;
    assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_number_match_engine.sv
// tb/tb_number_match_engine.sv - randomized directed bench for number_match_engine against a round-level model
module tb_number_match_engine;

    localparam int W      = 4;
    localparam int GEN_C  = 4;
    localparam int HOLD_C = 3;
    localparam int MAX_A  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         guess_valid = 1'b0;
    logic [W-1:0] guess = '0;
    logic         match;
    logic         not_match;
    logic [W-1:0] target;
    logic         busy;
    logic         game_over;

    int           compared = 0;
    int           mismatched = 0;
    int           edges = 0;
    logic [W-1:0] exp_target = '0;
    int           misses = 0;

    number_match_engine #(
        .WIDTH(W),
        .GEN_CYCLES(GEN_C),
        .HOLD_CYCLES(HOLD_C),
        .MAX_ATTEMPTS(MAX_A)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .guess_valid(guess_valid),
        .guess(guess),
        .match(match),
        .not_match(not_match),
        .target(target),
        .busy(busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Clock edges seen since the last reset release; the LFSR advances once per edge
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    function automatic logic [15:0] lfsr_after(input int e);
        int v;
        v = 'hACE1;
        for (int k = 0; k < e; k++) begin
            v = (v >> 1) | ((((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1) << 15);
        end
        return 16'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round();
        int          n;
        logic [15:0] l;
        repeat ($urandom_range(0, 2)) begin
            step();
            check("idle_busy", busy, 0);
        end
        check("idle_target_hold", target, exp_target);
        start       = 1'b1;
        guess_valid = 1'($urandom_range(0, 1));
        guess       = 4'($urandom);
        n           = edges + 1;
        step();
        guess_valid = 1'b0;
        l           = lfsr_after(n + GEN_C - 1);
        exp_target  = l[W-1:0];
        misses      = 0;
        for (int i = 0; i < GEN_C; i++) begin
            check("gen_busy", busy, 1);
            check("gen_quiet", {match, not_match}, 2'b00);
            start = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0;
        check("gen_target", target, exp_target);
        check("wait_busy_entry", busy, 1);
    endtask

    task automatic guess_once(input logic [W-1:0] g, output bit hit, output bit lim);
        repeat ($urandom_range(0, 3)) begin
            start = 1'($urandom_range(0, 1));
            step();
            check("wait_busy", busy, 1);
            check("wait_target", target, exp_target);
            check("wait_quiet", {match, not_match}, 2'b00);
        end
        start       = 1'b0;
        guess       = g;
        guess_valid = 1'b1;
        step();
        hit = (g == exp_target);
        if (!hit) misses++;
`ifdef ATTEMPT_LIMIT_EN
        lim = !hit && (misses >= MAX_A);
`else
        lim = 1'b0;
`endif
        guess_valid = 1'($urandom_range(0, 1));
        guess       = ~g;
        check("check_quiet", {match, not_match}, 2'b00);
        step();
        for (int i = 0; i < HOLD_C; i++) begin
            check(hit ? "show_match" : "show_miss", {match, not_match}, hit ? 2'b10 : 2'b01);
            check("show_busy", busy, 1);
            start       = 1'($urandom_range(0, 1));
            guess_valid = 1'($urandom_range(0, 1));
            guess       = 4'($urandom);
            step();
        end
        start       = 1'b0;
        guess_valid = 1'b0;
        check("exit_busy", busy, !(hit || lim));
        check("exit_quiet", {match, not_match}, 2'b00);
        check("game_over_pulse", game_over, lim);
        check("exit_target", target, exp_target);
        if (hit || lim) begin
            step();
            check("game_over_clear", game_over, 0);
            check("idle_stays", busy, 0);
        end
    endtask

    initial begin
        bit           hit;
        bit           lim;
        int           tries;
        logic [W-1:0] g;

        repeat (3) step();
        check("rst_match", match, 0);
        check("rst_not_match", not_match, 0);
        check("rst_busy", busy, 0);
        check("rst_target", target, 0);
        check("rst_game_over", game_over, 0);
        rst = 1'b0;
        step();
        check("post_rst_busy", busy, 0);

        // Near miss first, then the correct number
        start_round();
        guess_once(exp_target ^ 4'h1, hit, lim);
        guess_once(exp_target, hit, lim);

        // Miss limit: with the limit the last miss ends the round, otherwise play continues
        start_round();
        for (int k = 0; k < MAX_A; k++) guess_once(exp_target ^ 4'h2, hit, lim);
`ifndef ATTEMPT_LIMIT_EN
        guess_once(exp_target ^ 4'h3, hit, lim);
        guess_once(exp_target, hit, lim);
`endif

        repeat (6) begin
            start_round();
            tries = 0;
            do begin
                g = (tries >= 4) ? exp_target : 4'($urandom);
                guess_once(g, hit, lim);
                tries++;
            end while (!hit && !lim);
        end

        // Reset during the second SHOW_MATCH cycle
        start_round();
        guess       = exp_target;
        guess_valid = 1'b1;
        step();
        guess_valid = 1'b0;
        step();
        step();
        check("pre_abort_match", match, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_match", match, 0);
        check("abort_not_match", not_match, 0);
        check("abort_busy", busy, 0);
        check("abort_target", target, 0);
        step();
        rst = 1'b0;
        exp_target = '0;
        step();
        check("release_quiet", {match, not_match}, 2'b00);
        check("release_busy", busy, 0);
        start_round();
        guess_once(exp_target, hit, lim);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
